// File: rtl/lock_pkg.sv
// rtl/lock_pkg.sv - shared types and constants for the combination lock front end
package lock_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        HELD,
        RELEASE_WAIT
    } deb_state_t;

    localparam int SEQ_LEN   = 6;
    localparam int DIGIT_W   = 4;
    localparam int MAX_DIGIT = 9;

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - enter button synchroniser, debounce FSM and accept pulse
module btn_debounce
    import lock_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_n,
    output logic btn_level,
    output logic accept
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic            r_sync1;
    logic            r_sync2;
    deb_state_t      r_state;
    deb_state_t      w_state_nxt;
    logic [CW-1:0]   r_cnt;
    logic [CW-1:0]   w_cnt_nxt;
    logic            w_pressed;

    assign w_pressed = ~r_sync2;

    // Two-flop synchroniser; resets to the released level so a held button reads as a fresh press
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= btn_n;
            r_sync2 <= r_sync1;
        end
    end

    // State and stability counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next state: a level change must persist for DEBOUNCE_CYCLES more samples; accept fires on the press side only
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        btn_level   = 1'b0;
        accept      = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_pressed) begin
                    w_state_nxt = PRESS_WAIT;
                    w_cnt_nxt   = '0;
                end
            end
            PRESS_WAIT: begin
                if (!w_pressed) begin
                    w_state_nxt = IDLE;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt = HELD;
                    accept      = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            HELD: begin
                btn_level = 1'b1;
                if (!w_pressed) begin
                    w_state_nxt = RELEASE_WAIT;
                    w_cnt_nxt   = '0;
                end
            end
            RELEASE_WAIT: begin
                btn_level = 1'b1;
                if (w_pressed) begin
                    w_state_nxt = HELD;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

endmodule

// File: rtl/digit_entry.sv
// rtl/digit_entry.sv - one digit strobe per debounced press with capture, range flag and count
module digit_entry
    import lock_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int SEQ_LEN         = lock_pkg::SEQ_LEN
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_n,
    input  logic [3:0] sw,
    output logic [3:0] digit_out,
    output logic       digit_stb,
    output logic       digit_bad,
    output logic [2:0] entry_cnt,
    output logic       seq_done,
    output logic       btn_level
);

    localparam logic [DIGIT_W-1:0] MAX_D    = DIGIT_W'(MAX_DIGIT);
    localparam logic [2:0]         CNT_FULL = 3'(SEQ_LEN);

    logic             w_accept;
    logic             w_seq_done;
    logic [3:0]       r_digit;
    logic             r_stb;
    logic             r_bad;
    logic [2:0]       r_cnt;

    btn_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_btn_debounce (
        .clk       (clk),
        .rst       (rst),
        .btn_n     (btn_n),
        .btn_level (btn_level),
        .accept    (w_accept)
    );

    assign w_seq_done = (r_cnt == CNT_FULL);

    // Capture the switches on an accepted press until the attempt is full
    always_ff @(posedge clk) begin
        if (rst) begin
            r_digit <= '0;
            r_stb   <= 1'b0;
            r_bad   <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_stb <= 1'b0;
            if (w_accept && !w_seq_done) begin
                r_digit <= sw;
                r_bad   <= (sw > MAX_D);
                r_cnt   <= r_cnt + 3'd1;
                r_stb   <= 1'b1;
            end
        end
    end

    assign digit_out = r_digit;
    assign digit_stb = r_stb;
    assign digit_bad = r_bad;
    assign entry_cnt = r_cnt;
    assign seq_done  = w_seq_done;

endmodule
